psum_eject_collector: RTL and testbench

//  Downstream of the 16x16 transposed-conv systolic array. Captures the Dimension row

---
 rtl/psum_eject_collector_pkg.sv | 19 +
 rtl/psum_sat_add.sv | 26 ++
 rtl/psum_eject_collector.sv | 147 ++++++++++++++
 tb/tb_psum_eject_collector.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_eject_collector_pkg.sv
// rtl/psum_eject_collector_pkg.sv - shared defaults, FSM encoding and saturation limits for the psum eject collector
package psum_eject_collector_pkg;

  localparam int DW_DEF     = 16;
  localparam int DIM_DEF    = 16;
  localparam int ADDR_W_DEF = 10;

  localparam logic signed [DW_DEF-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DW_DEF-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_CAPT  = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

endpackage

// File: rtl/psum_sat_add.sv
// rtl/psum_sat_add.sv - lane-wise signed add with clamp to the DW-bit range
module psum_sat_add #(
  parameter int DW    = 16,
  parameter int LANES = 16
) (
  input  logic [DW*LANES-1:0] a,
  input  logic [DW*LANES-1:0] b,
  output logic [DW*LANES-1:0] sum,
  output logic [LANES-1:0]    sat
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0] a_l;
    logic [DW-1:0] b_l;
    logic [DW:0]   wide;

    assign a_l  = a[DW*i +: DW];
    assign b_l  = b[DW*i +: DW];
    assign wide = {a_l[DW-1], a_l} + {b_l[DW-1], b_l};
    // The top two bits of the DW+1 sum disagree exactly when the result left the DW range.
    assign sat[i] = wide[DW] ^ wide[DW-1];
    assign sum[DW*i +: DW] = !sat[i] ? wide[DW-1:0] :
                             (wide[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
  end

endmodule

// File: rtl/psum_eject_collector.sv
// rtl/psum_eject_collector.sv - captures ejected array rows, optionally accumulates with stored psums, drains over ready/valid
module psum_eject_collector
  import psum_eject_collector_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int Dimension = DIM_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int EJECT_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    eject_start,
  input  logic                    accum_en,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [DW*Dimension-1:0] array_out,
  output logic                    psum_rd_en,
  output logic [ADDR_W-1:0]       psum_rd_addr,
  input  logic [DW*Dimension-1:0] psum_rd_data,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DW*Dimension-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    sat_flag,
  output logic                    drop_err
);

  localparam int ROW_W = DW * Dimension;
  localparam int IDX_W = $clog2(Dimension);
  localparam int LAT_W = (EJECT_LAT > 1) ? $clog2(EJECT_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(Dimension - 1);

  state_t            state;
  logic [LAT_W-1:0]  wait_cnt;
  logic [IDX_W-1:0]  cap_idx;
  logic [IDX_W-1:0]  row;
  logic              accum_q;
  logic [ADDR_W-1:0] base_q;
  logic              first_q;
  logic [ROW_W-1:0]  psum_hold;
  logic [ROW_W-1:0]  row_buf [Dimension];
  logic [ROW_W-1:0]  addend;
  logic [ROW_W-1:0]  sum;
  logic [Dimension-1:0] sat_vec;
  logic [ADDR_W-1:0] row_addr;

  assign row_addr = base_q + ADDR_W'(row);
  // BRAM data is only valid in the first WRITE cycle; later stall cycles use the held copy.
  assign addend   = !accum_q ? '0 : (first_q ? psum_rd_data : psum_hold);

  psum_sat_add #(
    .DW    (DW),
    .LANES (Dimension)
  ) u_sat_add (
    .a   (row_buf[row]),
    .b   (addend),
    .sum (sum),
    .sat (sat_vec)
  );

  assign busy         = (state != S_IDLE);
  assign wr_valid     = (state == S_WRITE);
  assign psum_rd_en   = (state == S_READ) && accum_q;
  assign psum_rd_addr = psum_rd_en ? row_addr : '0;
  assign wr_addr      = wr_valid ? row_addr : '0;
  assign wr_data      = wr_valid ? sum : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      cap_idx  <= '0;
      row      <= '0;
      accum_q  <= 1'b0;
      base_q   <= '0;
      first_q  <= 1'b0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      done <= 1'b0;
      // A start that lands while done is pulsing belongs to the finishing sequence's window.
      if (eject_start && (state != S_IDLE || done)) begin
        drop_err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (eject_start && !done) begin
            accum_q  <= accum_en;
            base_q   <= base_addr;
            wait_cnt <= LAT_W'(EJECT_LAT - 1);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            cap_idx <= '0;
            state   <= S_CAPT;
          end else begin
            wait_cnt <= wait_cnt - LAT_W'(1);
          end
        end
        S_CAPT: begin
          cap_idx <= cap_idx + IDX_W'(1);
          if (cap_idx == LAST) begin
            row   <= '0;
            state <= S_READ;
          end
        end
        S_READ: begin
          first_q <= 1'b1;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          first_q <= 1'b0;
          if (wr_ready) begin
            if (|sat_vec) begin
              sat_flag <= 1'b1;
            end
            if (row == LAST) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              row   <= row + IDX_W'(1);
              state <= S_READ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_CAPT) begin
      row_buf[cap_idx] <= array_out;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_WRITE && first_q) begin
      psum_hold <= psum_rd_data;
    end
  end

endmodule

// File: tb/tb_psum_eject_collector.sv
// tb/tb_psum_eject_collector.sv - self-checking bench: vector table, directed corner sequences and randomized drains
module tb_psum_eject_collector;
  import psum_eject_collector_pkg::*;

  localparam int DW  = 16;
  localparam int DIM = 16;
  localparam int AW  = 10;
  localparam int LAT = 1;
  localparam int RW  = DW * DIM;

  logic          clk = 1'b0;
  logic          rst;
  logic          eject_start;
  logic          accum_en;
  logic [AW-1:0] base_addr;
  logic [RW-1:0] array_out;
  logic          psum_rd_en;
  logic [AW-1:0] psum_rd_addr;
  logic [RW-1:0] psum_rd_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [RW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          sat_flag;
  logic          drop_err;

  always #5 clk = ~clk;

  psum_eject_collector #(
    .DW(DW), .Dimension(DIM), .ADDR_W(AW), .EJECT_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .eject_start(eject_start), .accum_en(accum_en),
    .base_addr(base_addr), .array_out(array_out), .psum_rd_en(psum_rd_en),
    .psum_rd_addr(psum_rd_addr), .psum_rd_data(psum_rd_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .sat_flag(sat_flag), .drop_err(drop_err)
  );

  typedef struct {
    logic [AW-1:0] base;
    bit            acc;
    int            stored;
    int            beat;
    int            exp_lane;
    bit            exp_sticky;
  } vec_t;

  int            checks   = 0;
  int            failures = 0;
  logic [RW-1:0] mem [1<<AW];
  logic [RW-1:0] beats [DIM];
  bit            exp_sat  = 1'b0;
  bit            exp_drop = 1'b0;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] junk();
    logic [RW-1:0] r;
    for (int w = 0; w < RW / 32; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [RW-1:0] fill(input int v);
    logic [RW-1:0] r;
    for (int i = 0; i < DIM; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic int lane_of(input logic [RW-1:0] v, input int i);
    logic signed [DW-1:0] t;
    t = v[i*DW +: DW];
    return int'(t);
  endfunction

  // Reference: plain integer add per lane, then clamp to the signed DW range.
  function automatic logic [RW-1:0] model_row(input logic [RW-1:0] beat, input logic [RW-1:0] stored,
                                              input bit acc, output bit sat);
    logic [RW-1:0] r;
    int s;
    sat = 1'b0;
    for (int i = 0; i < DIM; i++) begin
      s = lane_of(beat, i) + (acc ? lane_of(stored, i) : 0);
      if (s > int'(SAT_MAX)) begin s = int'(SAT_MAX); sat = 1'b1; end
      if (s < int'(SAT_MIN)) begin s = int'(SAT_MIN); sat = 1'b1; end
      r[i*DW +: DW] = s[DW-1:0];
    end
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_wr_valid"}, wr_valid, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_rd_en"}, psum_rd_en, 0);
    check({tag, "_rd_addr"}, psum_rd_addr, 0);
    check({tag, "_sat_flag"}, sat_flag, 0);
    check({tag, "_drop_err"}, drop_err, 0);
  endtask

  // Runs one eject from the current (post-edge) point. coll_at: cycle of a second eject_start
  // (-1 none). rst_after: pulse reset after that many accepted writes (-1 none).
  task automatic run_seq(input logic [AW-1:0] base, input bit acc, input int ready_pct,
                         input int coll_at, input int rst_after);
    logic [AW-1:0] ea[$];
    logic [RW-1:0] ed[$];
    logic [AW-1:0] a, pa, rd_a;
    logic [RW-1:0] pd;
    bit s, seq_sat, rd_req, prev_stall, fin;
    int nwr, ndone, done_cyc, stalls, nrd, stall_err, rd_err, busy_err, quiet_err, rst_at, k;
    seq_sat = 0; rd_req = 0; prev_stall = 0; fin = 0; pa = '0; pd = '0; rd_a = '0;
    nwr = 0; ndone = 0; done_cyc = -1; stalls = 0; nrd = 0;
    stall_err = 0; rd_err = 0; busy_err = 0; quiet_err = 0; rst_at = -1;
    for (int r = 0; r < DIM; r++) begin
      a = base + AW'(r);
      ea.push_back(a);
      ed.push_back(model_row(beats[r], mem[a], acc, s));
      seq_sat |= s;
    end
    eject_start = 1'b1; accum_en = acc; base_addr = base;
    wr_ready = ($urandom % 100) < ready_pct;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      @(negedge clk);
      if (rst_at >= 0) begin
        rd_req = 1'b0;
        if (cyc == rst_at + 2) check_zero("rst_mid");
        if (cyc > rst_at + 2 && wr_valid) quiet_err++;
        if (cyc >= rst_at + 6) fin = 1'b1;
      end else begin
        if (done) begin ndone++; done_cyc = cyc; end
        if (busy !== (cyc >= 1 && ndone == 0)) busy_err++;
        if (prev_stall && (!wr_valid || wr_addr !== pa || wr_data !== pd)) stall_err++;
        prev_stall = wr_valid && !wr_ready;
        pa = wr_addr; pd = wr_data;
        if (prev_stall) stalls++;
        rd_req = psum_rd_en; rd_a = psum_rd_addr;
        if (psum_rd_en) begin
          nrd++;
          if (ea.size() == 0 || psum_rd_addr !== ea[0]) rd_err++;
        end
        if (wr_valid && wr_ready) begin
          if (ea.size() > 0) begin
            check($sformatf("wr_addr_row%0d", nwr), wr_addr, ea.pop_front());
            check($sformatf("wr_data_row%0d", nwr), wr_data, ed.pop_front());
          end
          mem[wr_addr] = wr_data;
          nwr++;
          if (nwr == rst_after) rst_at = cyc;
        end
        if (ndone > 0 && cyc >= done_cyc + 3) fin = 1'b1;
      end
      @(posedge clk); #1;
      eject_start = (cyc + 1 == coll_at);
      accum_en    = $urandom % 2;
      base_addr   = AW'($urandom);
      k = cyc + 1 - (LAT + 1);
      array_out    = (k >= 0 && k < DIM) ? beats[k] : junk();
      psum_rd_data = rd_req ? mem[rd_a] : junk();
      wr_ready     = ($urandom % 100) < ready_pct;
      rst          = !(rst_at >= 0 && cyc + 1 == rst_at + 1);
    end
    eject_start = 1'b0;
    rst = 1'b1;
    check("seq_terminated", fin, 1);
    if (rst_at >= 0) begin
      exp_sat = 1'b0; exp_drop = 1'b0;
      check("post_reset_quiet", quiet_err, 0);
    end else begin
      exp_sat  |= seq_sat;
      exp_drop |= (coll_at >= 0);
      check("n_writes", nwr, DIM);
      check("n_done", ndone, 1);
      check("done_cycle", done_cyc, LAT + 3 * DIM + 1 + stalls);
      check("stall_stable", stall_err, 0);
      check("rd_addr_match", rd_err, 0);
      check("n_reads", nrd, acc ? DIM : 0);
      check("busy_window", busy_err, 0);
      check("sat_flag", sat_flag, exp_sat);
      check("drop_err", drop_err, exp_drop);
    end
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = '{10'h020, 1'b1,    100,     5,    105, 1'b0};
    tbl[1] = '{10'h040, 1'b0,    777,    -5,     -5, 1'b0};
    tbl[2] = '{10'h060, 1'b1,  32767,     0,  32767, 1'b0};
    tbl[3] = '{10'h080, 1'b1,  32000,  1000,  32767, 1'b1};
    tbl[4] = '{10'h0A0, 1'b1, -32000, -1000, -32768, 1'b1};
    tbl[5] = '{10'h0C0, 1'b1, -32768,    -1, -32768, 1'b1};
    tbl[6] = '{10'h0E0, 1'b1,      1,     2,      3, 1'b1};

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rst = 1'b0; eject_start = 1'b0; accum_en = 1'b0; base_addr = '0;
    array_out = '0; psum_rd_data = '0; wr_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Overwrite, incrementing lane pattern, no stall.
    for (int k = 0; k < DIM; k++)
      for (int i = 0; i < DIM; i++) beats[k][i*DW +: DW] = DW'(k * 16 + i);
    run_seq(10'h010, 1'b0, 100, -1, -1);

    // Uniform-lane vectors covering pass-through, accumulate and both clamp directions.
    foreach (tbl[t]) begin
      for (int r = 0; r < DIM; r++) begin
        mem[tbl[t].base + AW'(r)] = fill(tbl[t].stored);
        beats[r] = fill(tbl[t].beat);
      end
      run_seq(tbl[t].base, tbl[t].acc, 100, -1, -1);
      for (int r = 0; r < DIM; r++)
        check($sformatf("tbl%0d_row%0d", t, r), mem[tbl[t].base + AW'(r)], fill(tbl[t].exp_lane));
      check($sformatf("tbl%0d_sticky", t), sat_flag, tbl[t].exp_sticky);
    end

    // Heavy backpressure with accumulate; held BRAM data must survive the stall.
    for (int r = 0; r < DIM; r++) begin mem[10'h200 + AW'(r)] = junk(); beats[r] = junk(); end
    run_seq(10'h200, 1'b1, 30, -1, -1);

    // Address wrap plus a colliding eject during capture.
    for (int r = 0; r < DIM; r++) beats[r] = junk();
    run_seq(10'h3FC, 1'b0, 100, LAT + 1 + 5, -1);

    // Reset after the third accepted write, then a fresh sequence.
    for (int r = 0; r < DIM; r++) begin mem[10'h100 + AW'(r)] = junk(); beats[r] = junk(); end
    run_seq(10'h100, 1'b1, 100, -1, 3);
    run_seq(10'h100, 1'b1, 70, -1, -1);

    for (int n = 0; n < 4; n++) begin
      logic [AW-1:0] b;
      b = AW'($urandom);
      for (int r = 0; r < DIM; r++) begin mem[b + AW'(r)] = junk(); beats[r] = junk(); end
      run_seq(b, 1'($urandom % 2), 20 + int'($urandom % 81), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
